// File: rtl/elm_pkg.sv
// Shared constants, activation-type encoding and the quantised sigmoid curve
// for the ELM fully-connected datapath.
package elm_pkg;

  localparam int DATA_WIDTH_DEF       = 16;
  localparam int FRAC_WIDTH_DEF       = 8;
  localparam int WEIGHT_INT_WIDTH_DEF = 8;
  localparam int SIGMOID_SIZE_DEF     = 10;

  typedef enum logic [1:0] {
    ACT_RELU         = 2'd0,
    ACT_SIGMOID      = 2'd1,
    ACT_SIGMOID_HALF = 2'd2,
    ACT_TRUNC        = 2'd3
  } act_type_e;

  // round-half-up(sigmoid(m/4) * 256) for magnitude m >= 0 (Q8.2 in, Q8.8 out).
  // From m = 25 (v = 6.25) on the result rounds to 1.0.
  function automatic int sigmoid_q(int m);
    int t;
    case (m)
      0:  t = 128;  1:  t = 144;  2:  t = 159;  3:  t = 174;  4:  t = 187;
      5:  t = 199;  6:  t = 209;  7:  t = 218;  8:  t = 225;  9:  t = 232;
      10: t = 237;  11: t = 241;  12: t = 244;  13: t = 246;  14: t = 248;
      15: t = 250;  16: t = 251;  17: t = 252;  18: t = 253;  19: t = 254;
      20: t = 254;  21: t = 255;  22: t = 255;  23: t = 255;  24: t = 255;
      default: t = (m < 0) ? 0 : 256;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/neuron_activation_if.sv
// Sample/result bundle between the neuron accumulator and its activation stage.
interface neuron_activation_if #(
  parameter int DATA_WIDTH = 16
);
  logic                    in_valid;
  logic [2*DATA_WIDTH-1:0] sum;
  logic [DATA_WIDTH-1:0]   out;
  logic                    out_valid;

  modport master (output in_valid, output sum, input out, input out_valid);
  modport slave  (input in_valid, input sum, output out, output out_valid);
endinterface

// File: rtl/act_sigmoid_rom.sv
// Synchronous-read sigmoid ROM. Full table is addressed in offset binary;
// the symmetric variant holds only the non-negative half.
module act_sigmoid_rom
  import elm_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_WIDTH = 8,
  parameter bit SYMMETRIC  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] o_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] w_table [DEPTH];
  logic [DATA_WIDTH-1:0] r_data;

  function automatic int rom_entry(int a);
    int x;
    if (SYMMETRIC) return sigmoid_q(a);
    x = a - DEPTH / 2;
    return (x < 0) ? (1 << FRAC_WIDTH) - sigmoid_q(-x) : sigmoid_q(x);
  endfunction

  for (genvar a = 0; a < DEPTH; a++) begin : g_tbl
    assign w_table[a] = DATA_WIDTH'(rom_entry(a));
  end

  always_ff @(posedge clk) begin
    if (!rst) r_data <= '0;
    else      r_data <= w_table[i_addr];
  end

  assign o_data = r_data;

endmodule

// File: rtl/neuron_activation.sv
// Registered activation stage: ReLU, sigmoid (full or half table) or truncation
// of the neuron accumulator, one cycle of latency for every type.
module neuron_activation
  import elm_pkg::*;
#(
  parameter int    DATA_WIDTH       = DATA_WIDTH_DEF,
  parameter int    FRAC_WIDTH       = FRAC_WIDTH_DEF,
  parameter int    WEIGHT_INT_WIDTH = WEIGHT_INT_WIDTH_DEF,
  parameter int    SIGMOID_SIZE     = SIGMOID_SIZE_DEF,
  parameter string ACT_TYPE         = "relu"
) (
  input  logic clk,
  input  logic rst,
  neuron_activation_if.slave bus
);

  localparam int SUM_W  = 2 * DATA_WIDTH;
  localparam int WIN_HI = SUM_W - 1 - WEIGHT_INT_WIDTH;
  localparam act_type_e ACT =
    (ACT_TYPE == "relu")         ? ACT_RELU :
    (ACT_TYPE == "sigmoid")      ? ACT_SIGMOID :
    (ACT_TYPE == "sigmoid_half") ? ACT_SIGMOID_HALF : ACT_TRUNC;

  logic [SUM_W-1:0] w_sum;
  logic             w_unused_sum;
  logic             r_valid;

  assign w_sum = bus.sum;
  // Fraction and guard bits are only needed by some activation types.
  assign w_unused_sum = ^w_sum;

  always_ff @(posedge clk) begin
    if (!rst) r_valid <= 1'b0;
    else      r_valid <= bus.in_valid;
  end

  assign bus.out_valid = r_valid;

  case (ACT)
    ACT_RELU: begin : g_relu
      logic [DATA_WIDTH-1:0] w_win;
      logic [DATA_WIDTH-1:0] r_out;
      assign w_win = w_sum[WIN_HI -: DATA_WIDTH];

      always_ff @(posedge clk) begin
        if (!rst)                                     r_out <= '0;
        else if (w_sum[SUM_W-1])                      r_out <= '0;
        else if (|w_sum[SUM_W-1 -: WEIGHT_INT_WIDTH+1]) r_out <= {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else                                          r_out <= w_win;
      end

      assign bus.out = r_out;
    end

    ACT_SIGMOID: begin : g_sig_full
      logic [SIGMOID_SIZE-1:0] w_x;
      logic [SIGMOID_SIZE-1:0] w_addr;
      assign w_x    = w_sum[WIN_HI -: SIGMOID_SIZE];
      assign w_addr = {~w_x[SIGMOID_SIZE-1], w_x[SIGMOID_SIZE-2:0]};

      act_sigmoid_rom #(
        .ADDR_WIDTH (SIGMOID_SIZE),
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_WIDTH (FRAC_WIDTH),
        .SYMMETRIC  (1'b0)
      ) u_rom (
        .clk    (clk),
        .rst    (rst),
        .i_addr (w_addr),
        .o_data (bus.out)
      );
    end

    ACT_SIGMOID_HALF: begin : g_sig_half
      logic [SIGMOID_SIZE-1:0] w_x;
      logic [SIGMOID_SIZE-1:0] w_neg_x;
      logic [SIGMOID_SIZE-2:0] w_addr;
      logic [DATA_WIDTH-1:0]   w_rom;
      logic                    r_neg;

      assign w_x     = w_sum[WIN_HI -: SIGMOID_SIZE];
      assign w_neg_x = -w_x;

      // Negative inputs fold onto the magnitude; the most-negative index clamps.
      always_comb begin
        w_addr = w_x[SIGMOID_SIZE-2:0];
        if (w_sum[SUM_W-1]) begin
          w_addr = w_neg_x[SIGMOID_SIZE-1] ? '1 : w_neg_x[SIGMOID_SIZE-2:0];
        end
      end

      always_ff @(posedge clk) begin
        if (!rst) r_neg <= 1'b0;
        else      r_neg <= w_sum[SUM_W-1];
      end

      act_sigmoid_rom #(
        .ADDR_WIDTH (SIGMOID_SIZE - 1),
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_WIDTH (FRAC_WIDTH),
        .SYMMETRIC  (1'b1)
      ) u_rom (
        .clk    (clk),
        .rst    (rst),
        .i_addr (w_addr),
        .o_data (w_rom)
      );

      assign bus.out = r_neg ? (DATA_WIDTH'(1 << FRAC_WIDTH) - w_rom) : w_rom;
    end

    default: begin : g_trunc
      logic [DATA_WIDTH-1:0] r_out;

      always_ff @(posedge clk) begin
        if (!rst) r_out <= '0;
        else      r_out <= w_sum[WIN_HI -: DATA_WIDTH];
      end

      assign bus.out = r_out;
    end
  endcase

endmodule

// File: tb/tb_neuron_activation.sv
// Drives all four activation variants with the same stream and checks each
// against a real-arithmetic reference of the activation functions.
module tb_neuron_activation;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  neuron_activation_if if_relu ();
  neuron_activation_if if_sig  ();
  neuron_activation_if if_half ();
  neuron_activation_if if_trn  ();

  neuron_activation #(.ACT_TYPE("relu"))         u_relu (.clk(clk), .rst(rst), .bus(if_relu));
  neuron_activation #(.ACT_TYPE("sigmoid"))      u_sig  (.clk(clk), .rst(rst), .bus(if_sig));
  neuron_activation #(.ACT_TYPE("sigmoid_half")) u_half (.clk(clk), .rst(rst), .bus(if_half));
  neuron_activation #(.ACT_TYPE("none"))         u_trn  (.clk(clk), .rst(rst), .bus(if_trn));

  // Reference functions, worked from real values of the Q16.16 accumulator.
  function automatic int relu_ref(longint s);
    if (s < 0) return 0;
    if (s >= (64'sd1 << 23)) return 32'h7FFF;   // 128.0 and above saturates
    return int'(s >>> 8);
  endfunction

  function automatic int trunc_ref(longint s);
    return int'((s >>> 8) & 64'hFFFF);
  endfunction

  function automatic int idx_of(longint s);
    int x;
    x = int'((s >>> 14) & 64'd1023);
    if (x >= 512) x -= 1024;
    return x;
  endfunction

  function automatic int sig_ref(int x);
    real v;
    v = real'(x) / 4.0;
    return int'($floor(256.0 / (1.0 + $exp(-v)) + 0.5));
  endfunction

  function automatic int half_ref(longint s);
    int x;
    int m;
    x = idx_of(s);
    if (s >= 0) return sig_ref(x);
    m = -x;
    if (m > 511) m = 511;
    return 256 - sig_ref(m);
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check1(input string tag, input logic got, input logic exp);
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // One cycle: drive at negedge, sample 1 time unit after the capturing edge.
  task automatic apply(input logic rst_v, input logic vld, input logic [31:0] s);
    longint ls;
    logic   e_v;
    int     e_r, e_s, e_h, e_t;
    @(negedge clk);
    rst = rst_v;
    if_relu.in_valid = vld; if_relu.sum = s;
    if_sig.in_valid  = vld; if_sig.sum  = s;
    if_half.in_valid = vld; if_half.sum = s;
    if_trn.in_valid  = vld; if_trn.sum  = s;
    @(posedge clk);
    #1;
    n_vec++;
    ls = longint'($signed(s));
    if (!rst_v) begin
      e_v = 1'b0; e_r = 0; e_s = 0; e_h = 0; e_t = 0;
    end else begin
      e_v = vld;
      e_r = relu_ref(ls);
      e_s = sig_ref(idx_of(ls));
      e_h = half_ref(ls);
      e_t = trunc_ref(ls);
    end
    check1("relu.valid", if_relu.out_valid, e_v);
    check1("sig.valid",  if_sig.out_valid,  e_v);
    check1("half.valid", if_half.out_valid, e_v);
    check1("trunc.valid", if_trn.out_valid, e_v);
    check("relu.out",  if_relu.out, 16'(e_r));
    check("sig.out",   if_sig.out,  16'(e_s));
    check("trunc.out", if_trn.out,  16'(e_t));
    // The folded table is defined for accumulators whose window holds the value.
    if (!rst_v || (ls >= -(64'sd1 << 23) && ls < (64'sd1 << 23)))
      check("half.out", if_half.out, 16'(e_h));
  endtask

  initial begin
    logic [31:0] r;
    if_relu.in_valid = 1'b0; if_relu.sum = '0;
    if_sig.in_valid  = 1'b0; if_sig.sum  = '0;
    if_half.in_valid = 1'b0; if_half.sum = '0;
    if_trn.in_valid  = 1'b0; if_trn.sum  = '0;

    // Reset state
    apply(1'b0, 1'b1, 32'h0003_8000);
    check("rst.relu", if_relu.out, 16'h0000);
    apply(1'b0, 1'b0, 32'h1234_5678);

    // ReLU directed points
    apply(1'b1, 1'b1, 32'h0003_8000);
    check("relu.3p5", if_relu.out, 16'h0380);
    check1("relu.3p5.valid", if_relu.out_valid, 1'b1);
    apply(1'b1, 1'b1, 32'hFFFF_0000);
    check("relu.neg", if_relu.out, 16'h0000);
    check("sig.m1",   if_sig.out,  16'd69);
    check("half.m1",  if_half.out, 16'd69);
    apply(1'b1, 1'b1, 32'h0100_0000);
    check("relu.sat", if_relu.out, 16'h7FFF);
    apply(1'b1, 1'b1, 32'h007F_FFFF);
    check("relu.maxwin", if_relu.out, 16'h7FFF);
    apply(1'b1, 1'b1, 32'h0080_0000);
    check("relu.sat128", if_relu.out, 16'h7FFF);
    check("trunc.wrap",  if_trn.out,  16'h8000);

    // Sigmoid directed points
    apply(1'b1, 1'b1, 32'h0000_0000);
    check("sig.zero",  if_sig.out,  16'd128);
    check("half.zero", if_half.out, 16'd128);
    apply(1'b1, 1'b1, 32'h0001_0000);
    check("sig.p1",  if_sig.out,  16'd187);
    check("half.p1", if_half.out, 16'd187);
    apply(1'b1, 1'b1, 32'hFF80_0000);
    check("sig.minx",  if_sig.out,  16'd0);
    check("half.minx", if_half.out, 16'd0);
    apply(1'b1, 1'b1, 32'h007F_C000);
    check("sig.maxx", if_sig.out, 16'd256);

    // Back-to-back ramp, then a bubble
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, 1'b1, 32'h0001_0000 + 32'(i) * 32'h0000_4000);
      check("ramp.relu", if_relu.out, 16'h0100 + 16'(i) * 16'h0040);
      check1("ramp.valid", if_relu.out_valid, 1'b1);
    end
    apply(1'b1, 1'b0, 32'h0000_8000);
    check1("bubble.valid", if_relu.out_valid, 1'b0);
    check("bubble.out", if_relu.out, 16'h0080);

    // Reset mid-stream drops the in-flight result
    apply(1'b1, 1'b1, 32'h0002_0000);
    apply(1'b0, 1'b1, 32'h0003_0000);
    check("midrst.relu", if_relu.out, 16'h0000);
    check1("midrst.valid", if_relu.out_valid, 1'b0);
    apply(1'b1, 1'b1, 32'h0004_0000);
    check("resume.relu", if_relu.out, 16'h0400);
    check1("resume.valid", if_relu.out_valid, 1'b1);

    // Full sweep of the sigmoid index
    for (int x = -512; x < 512; x++) begin
      apply(1'b1, 1'b1, 32'(x * 16384));
    end

    // Randomised traffic, mostly in-window accumulators
    for (int i = 0; i < 2000; i++) begin
      r = $urandom;
      if ($urandom_range(3) != 0) r = {{8{r[23]}}, r[23:0]};
      apply(1'b1, 1'($urandom_range(1)), r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/neuron_activation.md
# neuron_activation

Registered activation-function stage for one neuron of the fully-connected ELM datapath. It takes the neuron's full-precision accumulator (weighted sum plus bias) and produces one `DATA_WIDTH` activation value. The function is selected at elaboration: ReLU, full-table sigmoid, half-table symmetric sigmoid, or plain truncation. It sits between the neuron MAC/accumulator and the next layer's input.

## Interface
- `DATA_WIDTH`, 16: activation/data word width.
- `FRAC_WIDTH`, 8: fraction bits of data words; the accumulator carries 2·`FRAC_WIDTH`.
- `WEIGHT_INT_WIDTH`, 8: integer bits of the output window; must equal `DATA_WIDTH`−`FRAC_WIDTH`.
- `SIGMOID_SIZE`, 10: sigmoid table index width.
- `ACT_TYPE`, "relu": one of "relu", "sigmoid", "sigmoid_half"; any other value selects truncation.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-low reset (0 = reset).
- `in_valid` in 1: `sum` is valid this cycle.
- `sum` in 2·`DATA_WIDTH`: signed accumulator, Q(2·`DATA_WIDTH`−2·`FRAC_WIDTH`).(2·`FRAC_WIDTH`).
- `out` out `DATA_WIDTH`: activation result.
- `out_valid` out 1: `out` is valid.

## Operation
- Output window `win` = `sum`[2·`DATA_WIDTH`−1−`WEIGHT_INT_WIDTH` -: `DATA_WIDTH`]. With the defaults this is `sum`[23:8], a Q8.8 value.
- **ReLU**:
  - `sum` MSB = 1 → `out` = 0.
  - Otherwise, any 1 in `sum`[2·`DATA_WIDTH`−1 -: `WEIGHT_INT_WIDTH`+1] → saturate `out` = 0x7FFF (positive max).
  - Otherwise `out` = `win`.
- **Sigmoid index**: `x` = `sum`[2·`DATA_WIDTH`−1−`WEIGHT_INT_WIDTH` -: `SIGMOID_SIZE`], signed. Its real value is v = `x`/2^(`SIGMOID_SIZE`−`WEIGHT_INT_WIDTH`); with the defaults that is Q8.2.
- **sigmoid** (full table):
  - 2^`SIGMOID_SIZE` entries, address = `x` with its MSB inverted (offset binary).
  - Entry = round(σ(v)·2^`FRAC_WIDTH`), unsigned, zero-extended to `DATA_WIDTH`.
- **sigmoid_half** (symmetric table):
  - 2^(`SIGMOID_SIZE`−1) entries, one for each non-negative magnitude m, with value round(σ(m/2^(`SIGMOID_SIZE`−`WEIGHT_INT_WIDTH`))·2^`FRAC_WIDTH`).
  - `x` ≥ 0 → `out` = T[`x`].
  - `x` < 0 → `out` = 2^`FRAC_WIDTH` − T[min(|`x`|, 2^(`SIGMOID_SIZE`−1)−1)]. The clamp covers the most-negative `x`.
  - The sign is taken from the `sum` MSB.
- **Truncation**: `out` = `win`, with no saturation.
- Table contents are fixed at elaboration from an offline-generated init file or a constant function. Contents are bit-exact to the rounding rule above, with round-half-up.

## Timing
- Latency is 1 cycle for all types: `out` and `out_valid` are registered on the edge after the `sum`/`in_valid` sample.
- The stage is fully pipelined and accepts one input per cycle. There is no backpressure and no `ready` signal.
- `out_valid` is `in_valid` delayed by one cycle.
- `out` updates every cycle, whatever `in_valid` is. Consumers qualify it with `out_valid`.
- Reset (`rst`=0 at an edge): `out`=0 and `out_valid`=0 on that edge.
- Reset asserted mid-stream: the in-flight result is dropped.
- First valid input after reset release → valid output one cycle later.
- Both table variants must produce identical `out` for every `x` except the clamped most-negative entry. There the half table yields 2^`FRAC_WIDTH`−T[max].

## Structure
- Shared package `elm_pkg`:
  - `DATA_WIDTH`, `FRAC_WIDTH`, `WEIGHT_INT_WIDTH` and `SIGMOID_SIZE` defaults.
  - Activation-type encoding.
  - The sigmoid table init-file names.
- One natural sub-module, `act_sigmoid_rom`: a synchronous-read ROM with parameterised depth and init file, used by both sigmoid variants.
- ReLU and truncation stay inline.

## Test plan
- ReLU, `sum`=0x0003_8000 (3.5) → `out`=0x0380 one cycle later, `out_valid`=1.
- ReLU, `sum`=0xFFFF_0000 (−1.0) → `out`=0x0000. Then `sum`=0x0100_0000 (256.0) → `out`=0x7FFF (saturation).
- sigmoid, `sum`=0x0000_0000 → 128. `sum`=0x0001_0000 (`x`=4, v=1.0) → 187. `sum`=0xFFFF_0000 (`x`=−4) → 69.
- sigmoid_half, same three stimuli → 128, 187, 69. Sweep all 1024 `x` values and compare against the full table, excluding `x`=−512.
- Back-to-back: `in_valid` high for 5 cycles with ramping `sum` → 5 consecutive `out_valid` cycles, in order, each delayed by 1.
- Reset: `rst`=0 while `in_valid`=1 → `out`=0 and `out_valid`=0 on the next edge. Normal results resume one cycle after release.
